c2h_frame_buffer: RTL and testbench



---
 rtl/c2h_frame_buffer.sv | 186 ++++++++++++++++++
 tb/tb_c2h_frame_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2h_frame_buffer.sv
// c2h_frame_buffer: store-and-forward frame buffer feeding one C2H DMA port.
// AXI-stream frames in; length/tag descriptor plus pipelined word reads out.
module c2h_frame_buffer #(
    parameter int FRAME_DATA_WIDTH = 1024,
    parameter int LEN_WIDTH        = 16,
    parameter int TAG_WIDTH        = 8,
    parameter int DATA_DEPTH       = 64,
    parameter int DESC_DEPTH       = 8,
    parameter int TAG_BASE         = 1,
    parameter int FRAME_PIPELINE   = 1,
    localparam int BPW = FRAME_DATA_WIDTH / 8,
    localparam int CW  = $clog2(DESC_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [FRAME_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [BPW-1:0]              s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic                        read_frame_ready,
    output logic [LEN_WIDTH-1:0]        read_frame_len,
    output logic [TAG_WIDTH-1:0]        read_frame_tag,
    input  logic                        read_frame_enb,
    output logic [FRAME_DATA_WIDTH-1:0] read_frame_tdata,
    output logic [CW-1:0]               frame_count,
    output logic                        err_oversize,
    output logic                        err_underflow
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = $clog2(DESC_DEPTH);
    localparam int KW = $clog2(BPW) + 1;
    localparam int LW = LEN_WIDTH + 1;
    localparam int SH = $clog2(BPW);
    localparam logic [PW-1:0] DATA_CAP = PW'(DATA_DEPTH);
    localparam logic [CW-1:0] DESC_CAP = CW'(DESC_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
    state_t state, state_nx;

    logic [FRAME_DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [LEN_WIDTH-1:0]        desc_len [DESC_DEPTH];
    logic [TAG_WIDTH-1:0]        desc_tag [DESC_DEPTH];

    logic [PW-1:0]               wp, cp, rp, occ;
    logic [CW-1:0]               dwp, drp, dcount;
    logic [LEN_WIDTH-1:0]        byte_cnt, len_sum, wcnt, words, head_len;
    logic [TAG_WIDTH-1:0]        tag_cnt, head_tag;
    logic [KW-1:0]               keep_cnt;
    logic [LW-1:0]               sum, wsum;
    logic [FRAME_DATA_WIDTH-1:0] rd_word;
    logic ready_int, accept, in_frame, drop_go, commit, zero_len;
    logic rd_fire, last_word;

    assign occ       = wp - rp;
    assign dcount    = dwp - drp;
    assign ready_int = (state == DROP) ||
                       ((occ < DATA_CAP) && (dcount < DESC_CAP));
    assign s_axis_tready = rst_n && ready_int;
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign in_frame  = accept && (state != DROP);

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < BPW; i++)
            keep_cnt = keep_cnt + KW'(s_axis_tkeep[i]);
    end

    // Byte count saturates rather than wrapping on absurdly long frames.
    always_comb begin
        sum     = {1'b0, byte_cnt} +
                  (s_axis_tlast ? LW'(keep_cnt) : LW'(BPW));
        len_sum = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    end

    assign drop_go  = in_frame && !s_axis_tlast &&
                      (occ + PW'(1) == DATA_CAP);
    assign commit   = in_frame && s_axis_tlast && (len_sum != '0);
    assign zero_len = in_frame && s_axis_tlast && (len_sum == '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (drop_go) state_nx = DROP;
                  else if (accept && !s_axis_tlast) state_nx = RECV;
            RECV: if (drop_go) state_nx = DROP;
                  else if (accept && s_axis_tlast) state_nx = IDLE;
            DROP: if (accept && s_axis_tlast) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wp           <= '0;
            cp           <= '0;
            dwp          <= '0;
            byte_cnt     <= '0;
            tag_cnt      <= TAG_WIDTH'(TAG_BASE);
            err_oversize <= 1'b0;
        end else begin
            state <= state_nx;
            if (drop_go || zero_len) begin
                wp       <= cp;
                byte_cnt <= '0;
            end else if (commit) begin
                wp       <= wp + PW'(1);
                cp       <= wp + PW'(1);
                dwp      <= dwp + CW'(1);
                byte_cnt <= '0;
                tag_cnt  <= tag_cnt + TAG_WIDTH'(1);
            end else if (in_frame) begin
                wp       <= wp + PW'(1);
                byte_cnt <= len_sum;
            end
            if (drop_go)
                err_oversize <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_frame)
            mem[wp[AW-1:0]] <= s_axis_tdata;
        if (commit) begin
            desc_len[dwp[DW-1:0]] <= len_sum;
            desc_tag[dwp[DW-1:0]] <= tag_cnt;
        end
    end

    assign head_len         = desc_len[drp[DW-1:0]];
    assign head_tag         = desc_tag[drp[DW-1:0]];
    assign read_frame_ready = (dcount != '0);
    assign read_frame_len   = read_frame_ready ? head_len : '0;
    assign read_frame_tag   = read_frame_ready ? head_tag : '0;
    assign frame_count      = dcount;

    assign wsum      = {1'b0, head_len} + LW'(BPW - 1);
    assign words     = LEN_WIDTH'(wsum >> SH);
    assign rd_fire   = read_frame_enb && read_frame_ready;
    assign last_word = rd_fire && (wcnt + LEN_WIDTH'(1) == words);
    assign rd_word   = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp            <= '0;
            drp           <= '0;
            wcnt          <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (rd_fire)
                rp <= rp + PW'(1);
            if (last_word) begin
                wcnt <= '0;
                drp  <= drp + CW'(1);
            end else if (rd_fire) begin
                wcnt <= wcnt + LEN_WIDTH'(1);
            end
            if (read_frame_enb && !read_frame_ready)
                err_underflow <= 1'b1;
        end
    end

    generate
        if (FRAME_PIPELINE == 0) begin : g_comb
            assign read_frame_tdata = rd_fire ? rd_word : '0;
        end else begin : g_pipe
            logic [FRAME_DATA_WIDTH-1:0] pipe [FRAME_PIPELINE];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < FRAME_PIPELINE; k++)
                        pipe[k] <= '0;
                end else begin
                    if (rd_fire)
                        pipe[0] <= rd_word;
                    for (int k = 1; k < FRAME_PIPELINE; k++)
                        pipe[k] <= pipe[k-1];
                end
            end
            assign read_frame_tdata = pipe[FRAME_PIPELINE-1];
        end
    endgenerate

endmodule

// File: tb/tb_c2h_frame_buffer.sv
// tb_c2h_frame_buffer: scoreboard bench for c2h_frame_buffer.
// Writer pushes expected descriptors/words; consumer pops and compares.
module tb_c2h_frame_buffer;

    localparam int TAG_BASE = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] s_axis_tdata;
    logic [127:0]  s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          read_frame_ready;
    logic [15:0]   read_frame_len;
    logic [7:0]    read_frame_tag;
    logic          read_frame_enb;
    logic [1023:0] read_frame_tdata;
    logic [3:0]    frame_count;
    logic          err_oversize;
    logic          err_underflow;

    c2h_frame_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .read_frame_ready (read_frame_ready),
        .read_frame_len   (read_frame_len),
        .read_frame_tag   (read_frame_tag),
        .read_frame_enb   (read_frame_enb),
        .read_frame_tdata (read_frame_tdata),
        .frame_count      (frame_count),
        .err_oversize     (err_oversize),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int tag;
    } desc_t;

    desc_t         exp_desc[$];
    logic [1023:0] exp_data[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            exp_tag = TAG_BASE;
    int            fid = 0;
    int            drain_left = 0;
    bit            poke_enb = 1'b0;
    bit            pend_valid = 1'b0;
    logic [1023:0] pend_word = '0;
    logic [1023:0] last_word_exp = '0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [1023:0] got,
                              input logic [1023:0] exp);
        for (int q = 0; q < 4; q++)
            check($sformatf("%s_%0d", tag, q),
                  got[q*256 +: 256], exp[q*256 +: 256]);
    endtask

    function automatic logic [1023:0] mk_word(input int f, input int b);
        logic [1023:0] w;
        for (int i = 0; i < 32; i++)
            w[i*32 +: 32] = {f[15:0], b[7:0], 8'(i)};
        return w;
    endfunction

    function automatic logic [127:0] keep_mask(input int n);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 128; i++)
            if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    task automatic wait_accept();
        int  t;
        bit  ok;
        t = 0;
        forever begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 2000) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send_frame(input int len, input bit good);
        int nb;
        nb = (len == 0) ? 1 : (len + 127) / 128;
        if (good) begin
            exp_desc.push_back('{len: len, tag: exp_tag});
            for (int b = 0; b < nb; b++)
                exp_data.push_back(mk_word(fid, b));
            exp_tag = (exp_tag + 1) % 256;
        end
        for (int b = 0; b < nb; b++) begin
            s_axis_tdata  = mk_word(fid, b);
            s_axis_tkeep  = (b == nb - 1) ? keep_mask(len - b * 128)
                                          : '1;
            s_axis_tlast  = (b == nb - 1);
            s_axis_tvalid = 1'b1;
            wait_accept();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        fid++;
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        while ((exp_desc.size() != 0 || pend_valid) && t < 5000) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 5000)
            check("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_tready"}, s_axis_tready, 0);
        check({p, "_ready"}, read_frame_ready, 0);
        check({p, "_len"}, read_frame_len, 0);
        check({p, "_tag"}, read_frame_tag, 0);
        check_word({p, "_tdata"}, read_frame_tdata, '0);
        check({p, "_count"}, frame_count, 0);
        check({p, "_err_ovr"}, err_oversize, 0);
        check({p, "_err_und"}, err_underflow, 0);
    endtask

    // Consumer: one decision per cycle, data checked one cycle after enb.
    initial begin
        int widx;
        int cur_words;
        widx = 0;
        cur_words = 0;
        read_frame_enb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pend_valid) begin
                check_word("rd_data", read_frame_tdata, pend_word);
                pend_valid = 1'b0;
            end
            read_frame_enb = 1'b0;
            if (poke_enb) begin
                read_frame_enb = 1'b1;
            end else if (drain_left != 0 && read_frame_ready) begin
                if (exp_desc.size() == 0 || exp_data.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    if (widx == 0) begin
                        check("rd_len", read_frame_len, exp_desc[0].len);
                        check("rd_tag", read_frame_tag, exp_desc[0].tag);
                        cur_words = (exp_desc[0].len + 127) / 128;
                    end
                    read_frame_enb = 1'b1;
                    pend_word      = exp_data.pop_front();
                    pend_valid     = 1'b1;
                    last_word_exp  = pend_word;
                    widx++;
                    if (widx == cur_words) begin
                        widx = 0;
                        void'(exp_desc.pop_front());
                        if (drain_left > 0) drain_left--;
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("tready_after_rst", s_axis_tready, 1);

        send_frame(588, 1'b1);
        check("single_ready", read_frame_ready, 1);
        check("single_len", read_frame_len, 588);
        check("single_tag", read_frame_tag, 1);
        check("single_count1", frame_count, 1);
        drain_left = -1;
        wait_drained();
        check("single_count0", frame_count, 0);

        for (int i = 0; i < 300; i++)
            send_frame(48, 1'b1);
        wait_drained();
        check("wrap_count0", frame_count, 0);

        drain_left = 0;
        for (int i = 0; i < 8; i++)
            send_frame(48, 1'b1);
        check("full_tready", s_axis_tready, 0);
        check("full_count", frame_count, 8);
        drain_left = 1;
        t = 0;
        while (drain_left != 0 && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 100) check("full_drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #2;
        check("full_tready_back", s_axis_tready, 1);
        check("full_count7", frame_count, 7);
        drain_left = -1;
        wait_drained();

        send_frame(70 * 128, 1'b0);
        @(posedge clk);
        #2;
        check("ovr_err", err_oversize, 1);
        check("ovr_count", frame_count, 0);
        check("ovr_ready", read_frame_ready, 0);
        send_frame(88, 1'b1);
        wait_drained();

        @(negedge clk);
        poke_enb = 1'b1;
        @(negedge clk);
        poke_enb = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("und_err", err_underflow, 1);
        check_word("und_tdata", read_frame_tdata, last_word_exp);

        send_frame(0, 1'b0);
        @(posedge clk);
        #2;
        check("zero_count", frame_count, 0);
        check("zero_ready", read_frame_ready, 0);
        send_frame(100, 1'b1);
        wait_drained();

        for (int b = 0; b < 3; b++) begin
            s_axis_tdata  = mk_word(fid, b);
            s_axis_tkeep  = '1;
            s_axis_tlast  = 1'b0;
            s_axis_tvalid = 1'b1;
            if (b < 2) wait_accept();
        end
        @(posedge clk);
        #3;
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        fid++;
        exp_tag = TAG_BASE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("mid_rst_tready", s_axis_tready, 1);
        send_frame(200, 1'b1);
        check("post_rst_tag", read_frame_tag, TAG_BASE);
        wait_drained();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
